// File: rtl/vga_axil_pkg.sv
// Shared types and helpers for the VGA AXI4-Lite slave bridge.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package vga_axil_pkg;

  // AXI response codes used by the bridge.
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_t;

  typedef enum logic {
    W_COLLECT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  // Byte address to native word index. Only 32- and 64-bit data are supported.
  function automatic logic [63:0] word_index(input logic [63:0] addr, input int data_w);
    return (data_w == 64) ? (addr >> 3) : (addr >> 2);
  endfunction

  // A word index is decoded only when it lands inside the native register file.
  function automatic logic in_range(input logic [63:0] index, input int num_regs);
    return index < 64'(num_regs);
  endfunction

endpackage

// File: rtl/vga_axil_hold_reg.sv
// One-entry valid/ready hold register: captures a beat on handshake, keeps it until consume.
// Latency: held/hold_dat update on the capture edge; in_rdy is registered (drops the cycle after capture).
// Backpressure: in_rdy stays low while an entry is held; it returns the cycle after consume.
// Ports: clk, rst (sync, active-high), in_dat/in_vld/in_rdy (upstream), hold_dat/held (stored beat), consume.
module vga_axil_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] hold_dat,
  output logic         held,
  input  logic         consume
);

  always_ff @(posedge clk) begin
    if (rst) begin
      held     <= 1'b0;
      in_rdy   <= 1'b0;
      hold_dat <= '0;
    end else if (in_vld && in_rdy) begin
      hold_dat <= in_dat;
      held     <= 1'b1;
      in_rdy   <= 1'b0;
    end else if (consume) begin
      held     <= 1'b0;
      in_rdy   <= 1'b1;
    end else begin
      // Covers the first cycle after reset release as well as the idle case.
      in_rdy   <= !held;
    end
  end

endmodule

// File: rtl/vga_axil_slave_bridge.sv
// AXI4-Lite slave to native register-port bridge; independent write and read FSMs.
// Latency: write pulse + bvalid one cycle after the later AW/W handshake; rvalid READ_LATENCY+1 cycles after AR.
// Backpressure: one transaction per direction; readies stay low until the B/R response handshakes.
// Ports: clk, rst (sync, active-high); AXI-Lite slave s_aw*/s_w*/s_b*/s_ar*/s_r*;
//        native n_write_en/n_addr_write/n_data2native/n_wstrb and n_read_en/n_addr_read/n_data2axil.
module vga_axil_slave_bridge
  import vga_axil_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [DATA_W-1:0]           s_wdata,
  input  logic [DATA_W/8-1:0]         s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  input  logic [ADDR_W-1:0]           s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [DATA_W-1:0]           s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic                        n_write_en,
  output logic [$clog2(NUM_REGS)-1:0] n_addr_write,
  output logic [DATA_W-1:0]           n_data2native,
  output logic [DATA_W/8-1:0]         n_wstrb,
  output logic                        n_read_en,
  output logic [$clog2(NUM_REGS)-1:0] n_addr_read,
  input  logic [DATA_W-1:0]           n_data2axil
);

  localparam int NATIVE_ADDR_W = $clog2(NUM_REGS);
  localparam int STRB_W        = DATA_W / 8;
  localparam int CNT_W         = $clog2(READ_LATENCY + 1);

  // ---------------------------------------------------------------- write path
  wr_state_t                  wstate;
  logic                       aw_held;
  logic                       w_held;
  logic [ADDR_W-1:0]          aw_q;
  logic [DATA_W+STRB_W-1:0]   w_q;
  logic                       aw_have;
  logic                       w_have;
  logic                       wr_consume;
  logic [ADDR_W-1:0]          aw_addr_eff;
  logic                       wr_ok;

  assign wr_consume = s_bvalid && s_bready;

  vga_axil_hold_reg #(.W(ADDR_W)) u_aw_hold (
    .clk      (clk),
    .rst      (rst),
    .in_dat   (s_awaddr),
    .in_vld   (s_awvalid),
    .in_rdy   (s_awready),
    .hold_dat (aw_q),
    .held     (aw_held),
    .consume  (wr_consume)
  );

  vga_axil_hold_reg #(.W(DATA_W + STRB_W)) u_w_hold (
    .clk      (clk),
    .rst      (rst),
    .in_dat   ({s_wstrb, s_wdata}),
    .in_vld   (s_wvalid),
    .in_rdy   (s_wready),
    .hold_dat (w_q),
    .held     (w_held),
    .consume  (wr_consume)
  );

  // "Have" means held already or being captured on this edge, so the FSM can
  // leave W_COLLECT on the same edge as the later of the two handshakes.
  assign aw_have     = aw_held || (s_awvalid && s_awready);
  assign w_have      = w_held  || (s_wvalid  && s_wready);
  assign aw_addr_eff = aw_held ? aw_q : s_awaddr;
  assign wr_ok       = in_range(word_index(64'(aw_addr_eff), DATA_W), NUM_REGS);

  // The hold registers are stable for the whole W_RESP cycle, so the native
  // write payload is taken straight from them.
  assign n_addr_write             = NATIVE_ADDR_W'(word_index(64'(aw_q), DATA_W));
  assign {n_wstrb, n_data2native} = w_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate     <= W_COLLECT;
      n_write_en <= 1'b0;
      s_bvalid   <= 1'b0;
      s_bresp    <= OKAY;
    end else begin
      n_write_en <= 1'b0;
      if (wstate == W_COLLECT) begin
        if (aw_have && w_have) begin
          wstate     <= W_RESP;
          s_bvalid   <= 1'b1;
          n_write_en <= wr_ok;
          s_bresp    <= wr_ok ? OKAY : SLVERR;
        end
      end else if (s_bready) begin
        wstate   <= W_COLLECT;
        s_bvalid <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------- read path
  rd_state_t           rstate;
  logic [CNT_W-1:0]    rd_cnt;
  logic                rd_err;
  logic [63:0]         ar_idx;
  logic                rd_ok;

  assign ar_idx = word_index(64'(s_araddr), DATA_W);
  assign rd_ok  = in_range(ar_idx, NUM_REGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate      <= R_IDLE;
      s_arready   <= 1'b0;
      n_read_en   <= 1'b0;
      n_addr_read <= '0;
      rd_cnt      <= '0;
      rd_err      <= 1'b0;
      s_rvalid    <= 1'b0;
      s_rdata     <= '0;
      s_rresp     <= OKAY;
    end else begin
      n_read_en <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (s_arvalid && s_arready) begin
            rstate      <= R_WAIT;
            s_arready   <= 1'b0;
            rd_cnt      <= CNT_W'(READ_LATENCY);
            rd_err      <= !rd_ok;
            n_read_en   <= rd_ok;
            n_addr_read <= NATIVE_ADDR_W'(ar_idx);
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          // Out-of-range reads keep identical timing; only the data and code differ.
          rd_cnt <= rd_cnt - CNT_W'(1);
          if (rd_cnt == CNT_W'(1)) begin
            rstate   <= R_RESP;
            s_rvalid <= 1'b1;
            s_rdata  <= rd_err ? '0 : n_data2axil;
            s_rresp  <= rd_err ? SLVERR : OKAY;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            rstate    <= R_IDLE;
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_axil_slave_bridge.sv
module tb_vga_axil_slave_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic        n_write_en;
  logic [3:0]  n_addr_write;
  logic [31:0] n_data2native;
  logic [3:0]  n_wstrb;
  logic        n_read_en;
  logic [3:0]  n_addr_read;
  logic [31:0] n_data2axil;

  vga_axil_slave_bridge #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .n_write_en(n_write_en), .n_addr_write(n_addr_write), .n_data2native(n_data2native),
    .n_wstrb(n_wstrb), .n_read_en(n_read_en), .n_addr_read(n_addr_read),
    .n_data2axil(n_data2axil)
  );

  always #5 clk = ~clk;

  // edge_cnt = number of rising edges so far; the cycle after edge k is cycle k+1.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Native register file model: byte-strobed writes, read data follows the held read address.
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    mem[3] = 32'h1234_5678;
  end
  always @(posedge clk) begin
    if (n_write_en === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (n_wstrb[b]) mem[n_addr_write][b*8 +: 8] <= n_data2native[b*8 +: 8];
    end
  end
  assign n_data2axil = mem[n_addr_read];

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  r;
    int          cyc;
  } exp_t;

  exp_t nwq[$];
  exp_t nrq[$];
  exp_t bq[$];
  exp_t rq[$];

  function automatic exp_t mk(logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [1:0] r, int c);
    exp_t e;
    e.a = a; e.d = d; e.s = s; e.r = r; e.cyc = c;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, edge_cnt + 1);
    end
  endtask

  task automatic flag(string name, logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, edge_cnt + 1);
  endtask

  // ------------------------------------------------------------------ monitor
  logic b_prev = 1'b0, b_prev_rdy = 1'b0, r_prev = 1'b0, r_prev_rdy = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (n_write_en === 1'b1) begin
      if (nwq.size() == 0) flag("nwr_unexpected", 64'(n_addr_write));
      else begin
        e = nwq.pop_front();
        check("nwr_addr", 64'(n_addr_write), 64'(e.a));
        check("nwr_data", 64'(n_data2native), 64'(e.d));
        check("nwr_strb", 64'(n_wstrb), 64'(e.s));
        check("nwr_cycle", 64'(edge_cnt + 1), 64'(e.cyc));
      end
    end
    if (n_read_en === 1'b1) begin
      if (nrq.size() == 0) flag("nrd_unexpected", 64'(n_addr_read));
      else begin
        e = nrq.pop_front();
        check("nrd_addr", 64'(n_addr_read), 64'(e.a));
        check("nrd_cycle", 64'(edge_cnt + 1), 64'(e.cyc));
      end
    end
    if (s_bvalid === 1'b1) begin
      if (!b_prev) begin
        if (bq.size() == 0) flag("b_unexpected", 64'(s_bresp));
        else check("b_cycle", 64'(edge_cnt + 1), 64'(bq[0].cyc));
      end
      if (bq.size() != 0) begin
        check("bresp", 64'(s_bresp), 64'(bq[0].r));
        if (s_bready) void'(bq.pop_front());
      end
    end else if (b_prev && !b_prev_rdy) flag("bvalid_dropped", 64'(s_bvalid));
    if (s_rvalid === 1'b1) begin
      if (!r_prev) begin
        if (rq.size() == 0) flag("r_unexpected", 64'(s_rdata));
        else check("r_cycle", 64'(edge_cnt + 1), 64'(rq[0].cyc));
      end
      if (rq.size() != 0) begin
        check("rdata", 64'(s_rdata), 64'(rq[0].d));
        check("rresp", 64'(s_rresp), 64'(rq[0].r));
        if (s_rready) void'(rq.pop_front());
      end
    end else if (r_prev && !r_prev_rdy) flag("rvalid_dropped", 64'(s_rvalid));
    b_prev     <= (s_bvalid === 1'b1);
    b_prev_rdy <= s_bready;
    r_prev     <= (s_rvalid === 1'b1);
    r_prev_rdy <= s_rready;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each send returns the index of the edge on which its handshake happened.
  task automatic aw_send(input logic [31:0] a, output int k);
    k = -1;
    s_awaddr = a; s_awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_awready === 1'b1) begin
        tick();
        k = edge_cnt;
        break;
      end
      tick();
    end
    s_awvalid = 1'b0;
    if (k < 0) flag("aw_timeout", 64'(s_awready));
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, output int k);
    k = -1;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_wready === 1'b1) begin
        tick();
        k = edge_cnt;
        break;
      end
      tick();
    end
    s_wvalid = 1'b0;
    if (k < 0) flag("w_timeout", 64'(s_wready));
  endtask

  task automatic ar_send(input logic [31:0] a, output int k);
    k = -1;
    s_araddr = a; s_arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_arready === 1'b1) begin
        tick();
        k = edge_cnt;
        break;
      end
      tick();
    end
    s_arvalid = 1'b0;
    if (k < 0) flag("ar_timeout", 64'(s_arready));
  endtask

  task automatic wait_idle(string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (nwq.size() == 0 && nrq.size() == 0 && bq.size() == 0 && rq.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) flag({name, "_drain_timeout"}, 64'(nwq.size() + nrq.size() + bq.size() + rq.size()));
    tick();
    tick();
  endtask

  task automatic check_zero(string p);
    check({p, "_awready"}, 64'(s_awready), 0);
    check({p, "_wready"}, 64'(s_wready), 0);
    check({p, "_arready"}, 64'(s_arready), 0);
    check({p, "_bvalid"}, 64'(s_bvalid), 0);
    check({p, "_rvalid"}, 64'(s_rvalid), 0);
    check({p, "_bresp"}, 64'(s_bresp), 0);
    check({p, "_rresp"}, 64'(s_rresp), 0);
    check({p, "_rdata"}, 64'(s_rdata), 0);
    check({p, "_n_write_en"}, 64'(n_write_en), 0);
    check({p, "_n_read_en"}, 64'(n_read_en), 0);
    check({p, "_n_addr_write"}, 64'(n_addr_write), 0);
    check({p, "_n_addr_read"}, 64'(n_addr_read), 0);
    check({p, "_n_data2native"}, 64'(n_data2native), 0);
    check({p, "_n_wstrb"}, 64'(n_wstrb), 0);
  endtask

  task automatic check_readies(string p, logic v);
    check({p, "_awready"}, 64'(s_awready), 64'(v));
    check({p, "_wready"}, 64'(s_wready), 64'(v));
    check({p, "_arready"}, 64'(s_arready), 64'(v));
  endtask

  initial begin
    int ka, kw, kr;

    // Reset values and ready release.
    repeat (3) tick();
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    tick();
    @(negedge clk);
    check_readies("post_reset", 1'b1);
    tick();

    // 1: AW first, W three edges later; addr 0x08 -> word 2.
    aw_send(32'h08, ka);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t1_awready_low", 64'(s_awready), 0);
      tick();
    end
    w_send(32'hDEAD_BEEF, 4'hF, kw);
    nwq.push_back(mk(32'd2, 32'hDEAD_BEEF, 4'hF, 2'b00, kw + 1));
    bq.push_back(mk(0, 0, 0, 2'b00, kw + 1));
    check("t1_w_after_aw", 64'(kw - ka), 3);
    @(negedge clk);
    check("t1_awready_low_resp", 64'(s_awready), 0);
    tick();
    @(negedge clk);
    check("t1_awready_back", 64'(s_awready), 1);
    wait_idle("t1");

    // 2: read 0x0C -> word 3, native returns 0x12345678 after READ_LATENCY.
    ar_send(32'h0C, kr);
    nrq.push_back(mk(32'd3, 0, 0, 0, kr + 1));
    rq.push_back(mk(0, 32'h1234_5678, 0, 2'b00, kr + 1 + RL));
    @(negedge clk);
    check("t2_arready_low", 64'(s_arready), 0);
    wait_idle("t2");

    // 3: out-of-range write 0x40 and read 0x44 -> SLVERR, no native pulses.
    fork
      aw_send(32'h40, ka);
      w_send(32'h1111_2222, 4'hF, kw);
      ar_send(32'h44, kr);
    join
    bq.push_back(mk(0, 0, 0, 2'b10, kw + 1));
    rq.push_back(mk(0, 32'h0, 0, 2'b10, kr + 1 + RL));
    wait_idle("t3");

    // 4: responses stalled; strobed write to word 1, read of word 5.
    s_bready = 1'b0;
    s_rready = 1'b0;
    fork
      aw_send(32'h04, ka);
      w_send(32'h0BAD_F00D, 4'h3, kw);
      ar_send(32'h14, kr);
    join
    nwq.push_back(mk(32'd1, 32'h0BAD_F00D, 4'h3, 0, kw + 1));
    bq.push_back(mk(0, 0, 0, 2'b00, kw + 1));
    nrq.push_back(mk(32'd5, 0, 0, 0, kr + 1));
    rq.push_back(mk(0, 32'hA000_0005, 0, 2'b00, kr + 1 + RL));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_readies("t4_stall", 1'b0);
      tick();
    end
    s_bready = 1'b1;
    s_rready = 1'b1;
    wait_idle("t4");

    // 5: AW, W and AR in the same cycle; read word 1 sees the strobed merge.
    fork
      aw_send(32'h18, ka);
      w_send(32'h55AA_55AA, 4'hF, kw);
      ar_send(32'h04, kr);
    join
    check("t5_same_edge", 64'(kw - kr), 0);
    nwq.push_back(mk(32'd6, 32'h55AA_55AA, 4'hF, 0, kw + 1));
    bq.push_back(mk(0, 0, 0, 2'b00, kw + 1));
    nrq.push_back(mk(32'd1, 0, 0, 0, kr + 1));
    rq.push_back(mk(0, 32'hA000_F00D, 0, 2'b00, kr + 1 + RL));
    wait_idle("t5");

    // 6: reset while a read is waiting and a W beat is held.
    w_send(32'hCAFE_0000, 4'hF, kw);
    ar_send(32'h08, kr);
    nrq.push_back(mk(32'd2, 0, 0, 0, kr + 1));
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_zero("t6_reset");
    rst = 1'b0;
    tick();
    @(negedge clk);
    check_readies("t6_release", 1'b1);
    repeat (6) tick();
    // The dropped W beat must not pair with a fresh AW.
    aw_send(32'h1C, ka);
    repeat (4) tick();
    w_send(32'h0000_0077, 4'hF, kw);
    nwq.push_back(mk(32'd7, 32'h77, 4'hF, 0, kw + 1));
    bq.push_back(mk(0, 0, 0, 2'b00, kw + 1));
    wait_idle("t6");

    // Readback of words written earlier.
    ar_send(32'h18, kr);
    nrq.push_back(mk(32'd6, 0, 0, 0, kr + 1));
    rq.push_back(mk(0, 32'h55AA_55AA, 0, 2'b00, kr + 1 + RL));
    wait_idle("rb6");
    ar_send(32'h1C, kr);
    nrq.push_back(mk(32'd7, 0, 0, 0, kr + 1));
    rq.push_back(mk(0, 32'h0000_0077, 0, 2'b00, kr + 1 + RL));
    wait_idle("rb7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
